// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
//   Shares one byte-lane data memory between two requesters (port 0: CPU
//   load/store unit, port 1: I/O / DMA engine) using round-robin arbitration.
//   Each access runs IDLE -> SETUP -> PULSE -> DONE, one clock per state.
//   The arbiter owns the memory's address, data and control inputs, and it
//   generates the separate write and read clock pulses.
//
// Ports
//   clock, reset           system clock (rising edge), async active-low reset
//   pN_req/we/addr/wdata/type  request fields of port N (held until ack)
//   pN_ack                 one-cycle completion pulse for port N
//   pN_rdata               load result for port N, held until its next read ack
//   mem_data/addr/type     store data, byte address and access type to memory
//   mem_esc / mem_read     memory write / read enables
//   mem_write_clock        memory write clock pulse
//   mem_read_clock         memory read clock pulse
//   mem_saida              read data returned by the memory
//   busy                   high in every state except IDLE
//   grant                  port owning the current access (0 when idle)
module mem_access_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic [1:0]            p0_type,
  output logic                  p0_ack,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  input  logic [1:0]            p1_type,
  output logic                  p1_ack,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [1:0]            mem_type,
  output logic                  mem_esc,
  output logic                  mem_read,
  output logic                  mem_write_clock,
  output logic                  mem_read_clock,
  input  logic [DATA_WIDTH-1:0] mem_saida,
  output logic                  busy,
  output logic                  grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SETUP = 2'b01,
    PULSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic                  ptr_r;       // port that wins when both request
  logic                  port_r;      // port owning the access in flight
  logic                  we_r;        // latched write flag of that access
  logic                  start_s;     // a grant is issued this cycle
  logic                  sel_s;       // port being granted
  logic                  sel_we_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic [1:0]            sel_type_s;

  // Next-state logic and round-robin port selection
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    sel_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (p0_req && p1_req) begin
          start_s = 1'b1;
          sel_s   = ptr_r;
        end else if (p0_req) begin
          start_s = 1'b1;
          sel_s   = 1'b0;
        end else if (p1_req) begin
          start_s = 1'b1;
          sel_s   = 1'b1;
        end else begin
          start_s = 1'b0;
          sel_s   = 1'b0;
        end
        if (start_s) begin
          state_next_s = SETUP;
        end else begin
          state_next_s = IDLE;
        end
      end
      SETUP:   state_next_s = PULSE;
      PULSE:   state_next_s = DONE;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Request fields of the port being granted
  always_comb begin
    if (sel_s) begin
      sel_we_s    = p1_we;
      sel_addr_s  = p1_addr;
      sel_wdata_s = p1_wdata;
      sel_type_s  = p1_type;
    end else begin
      sel_we_s    = p0_we;
      sel_addr_s  = p0_addr;
      sel_wdata_s = p0_wdata;
      sel_type_s  = p0_type;
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Access latch, memory-side drive, acks and read-data capture.
  // Every output is set one edge ahead of the state in which it must be seen.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_r           <= 1'b0;
      port_r          <= 1'b0;
      we_r            <= 1'b0;
      mem_data        <= {DATA_WIDTH{1'b0}};
      mem_addr        <= {ADDR_WIDTH{1'b0}};
      mem_type        <= 2'b00;
      mem_esc         <= 1'b0;
      mem_read        <= 1'b0;
      mem_write_clock <= 1'b0;
      mem_read_clock  <= 1'b0;
      p0_ack          <= 1'b0;
      p1_ack          <= 1'b0;
      p0_rdata        <= {DATA_WIDTH{1'b0}};
      p1_rdata        <= {DATA_WIDTH{1'b0}};
      busy            <= 1'b0;
      grant           <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            // Pointer moves to the port that did not win this grant.
            ptr_r    <= ~sel_s;
            port_r   <= sel_s;
            we_r     <= sel_we_s;
            mem_addr <= sel_addr_s;
            mem_data <= sel_wdata_s;
            mem_type <= sel_type_s;
            mem_esc  <= sel_we_s;
            mem_read <= ~sel_we_s;
            busy     <= 1'b1;
            grant    <= sel_s;
          end
        end
        SETUP: begin
          mem_write_clock <= we_r;
          mem_read_clock  <= ~we_r;
        end
        PULSE: begin
          mem_write_clock <= 1'b0;
          mem_read_clock  <= 1'b0;
          mem_esc         <= 1'b0;
          mem_read        <= 1'b0;
          p0_ack          <= ~port_r;
          p1_ack          <= port_r;
          if (!we_r) begin
            if (port_r) begin
              p1_rdata <= mem_saida;
            end else begin
              p0_rdata <= mem_saida;
            end
          end
        end
        DONE: begin
          p0_ack <= 1'b0;
          p1_ack <= 1'b0;
          busy   <= 1'b0;
          grant  <= 1'b0;
        end
        default: begin
          mem_write_clock <= 1'b0;
          mem_read_clock  <= 1'b0;
          mem_esc         <= 1'b0;
          mem_read        <= 1'b0;
          p0_ack          <= 1'b0;
          p1_ack          <= 1'b0;
          busy            <= 1'b0;
          grant           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Sequences and shares the byte-lane data memory (32-bit data, byte/half/word access types, unaligned addressing) between two requesters: port 0 (CPU load/store unit) and port 1 (I/O / DMA engine).
- Owns the memory's control and address/data inputs and generates its separate write and read clock pulses from the single system clock.
- Returns each access result with a one-cycle ack.
- Arbitration is round-robin, so neither port starves.

Parameters:
- DATA_WIDTH, 32, width of data words on both ports and on the memory side.
- ADDR_WIDTH, 14, byte-address width on both ports and on the memory side.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- p0_req  in  1  port 0 access request.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  ADDR_WIDTH  port 0 byte address.
- p0_wdata  in  DATA_WIDTH  port 0 store data, right-aligned.
- p0_type  in  2  port 0 access type: 01 byte, 10 half, 00/11 word.
- p0_ack  out  1  port 0 one-cycle completion pulse.
- p0_rdata  out  DATA_WIDTH  port 0 load result.
- p1_req, p1_we, p1_addr, p1_wdata, p1_type, p1_ack, p1_rdata: identical to the port 0 signals, for port 1.
- mem_data  out  DATA_WIDTH  store data to the memory.
- mem_addr  out  ADDR_WIDTH  byte address to the memory.
- mem_type  out  2  access type to the memory.
- mem_esc  out  1  write enable to the memory.
- mem_read  out  1  read enable to the memory.
- mem_write_clock  out  1  write clock pulse to the memory.
- mem_read_clock  out  1  read clock pulse to the memory.
- mem_saida  in  DATA_WIDTH  read data from the memory.
- busy  out  1  high in every state except IDLE.
- grant  out  1  port owning the current access; 0 when IDLE.

Behaviour:
- The reset port is named reset. It is asynchronous and active-low.
- Reset values:
  - FSM = IDLE, priority pointer = 0.
  - All ack, mem_* outputs, busy and grant are 0.
  - p0_rdata and p1_rdata are 0.
  - Reset asserted mid-access aborts it immediately. The memory clocks drop at once, no ack is issued, and the aborted write's memory contents are undefined.
- All outputs are registered. Nothing is combinational from port inputs.
- FSM states: IDLE -> SETUP -> PULSE -> DONE -> IDLE. One clock per state.
- IDLE:
  - Sample p0_req and p1_req.
  - If exactly one is high, grant that port.
  - If both are high, grant the port selected by the pointer. The pointer is 0 after reset and flips to the other port after every grant.
  - On grant, latch that port's we/addr/wdata/type into internal registers and go to SETUP.
  - With no request, stay in IDLE.
- SETUP: drive mem_addr, mem_data and mem_type from the latch. Set mem_esc = we and mem_read = ~we. Both memory clocks are 0.
- PULSE:
  - Address, data and control are unchanged.
  - For a write, mem_write_clock = 1; for a read, mem_read_clock = 1. The other memory clock stays 0.
  - For a read, mem_saida is captured into the granted port's rdata at the rising edge that ends PULSE.
- DONE:
  - Both memory clocks are 0. mem_esc and mem_read drop to 0.
  - The granted port's ack = 1 for exactly this cycle. rdata is valid with ack and held until that port's next read ack.
  - A write leaves that port's rdata unchanged.
  - Next state is IDLE; grant returns to 0.
- Latency and throughput:
  - A request seen in IDLE at cycle t is acked at t+3.
  - Back-to-back accesses take 4 cycles each, one access in flight at a time.
- Handshake:
  - A requester holds req and its fields stable until it sees ack.
  - It must drop req in the cycle after ack unless it wants another access; req still high in IDLE is a new request.
  - Changing or dropping req after grant has no effect: the latched access completes and ack still pulses.
  - A request from the non-granted port waits; it is never lost while held high.
- Address and type pass to the memory unmodified; the arbiter performs no alignment check. Unaligned and wrap-around lane handling belong to the memory.
- Simultaneous events: both ports requesting in IDLE -> the pointer decides. The losing port is served at the next IDLE if it still holds req (its ack falls 4 cycles after the winner's).

Test Plan:
- Reset: hold reset = 0 with both reqs high -> all outputs 0, no ack. Release reset -> port 0 granted first (grant = 0 is the IDLE value, so check via p0_ack).
- Port 0 word write then read: write addr 0x0004, data 0xDEADBEEF, type 00, then read the same address.
  - Write: mem_write_clock pulses exactly 1 cycle, mem_read_clock stays 0.
  - Read: p0_ack at t+3 with p0_rdata = 0xDEADBEEF.
- Byte access on port 1: write 0xA5 at addr 0x0006, type 01, then read it back with type 01 -> p1_rdata = 0x000000A5; p0_rdata unchanged.
- Contention: both ports request continuously for 8 accesses -> grants alternate 0,1,0,1…; each ack is exactly 4 cycles apart; neither port starves.
- req dropped the cycle after grant -> ack still pulses at t+3 and no second access starts.
- Reset asserted during PULSE of a write -> mem_write_clock drops immediately, no ack; after release, the FSM is in IDLE with the pointer at 0.
